// File: rtl/iob_cache_write_buffer.sv
// Write-through buffer: an in-order FIFO of word writes feeding the back-end write channel.
// Optional same-cycle bypass of an empty buffer is enabled with IOB_CACHE_WTB_BYPASS_EN.
module iob_cache_write_buffer #(
  parameter int FE_ADDR_W   = 24,
  parameter int FE_DATA_W   = 32,
  parameter int DEPTH_W     = 2,
  parameter int FE_NBYTES   = FE_DATA_W / 8,
  parameter int FE_NBYTES_W = $clog2(FE_NBYTES),
  parameter int ENTRY_W     = (FE_ADDR_W - FE_NBYTES_W) + FE_DATA_W + FE_NBYTES
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             wtb_valid_i,
  input  logic [FE_ADDR_W-FE_NBYTES_W-1:0] wtb_addr_i,
  input  logic [FE_DATA_W-1:0]             wtb_wdata_i,
  input  logic [FE_NBYTES-1:0]             wtb_wstrb_i,
  output logic                             wtb_ready_o,
  output logic                             write_valid_o,
  output logic [FE_ADDR_W-FE_NBYTES_W-1:0] write_addr_o,
  output logic [FE_DATA_W-1:0]             write_wdata_o,
  output logic [FE_NBYTES-1:0]             write_wstrb_o,
  input  logic                             write_ready_i,
  output logic                             empty_o,
  output logic                             full_o,
  output logic [DEPTH_W:0]                 level_o
);

  localparam int WADDR_W = FE_ADDR_W - FE_NBYTES_W;
  localparam int DEPTH = 2 ** DEPTH_W;
  localparam logic [DEPTH_W:0] DEPTH_L = (DEPTH_W + 1)'(DEPTH);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [DEPTH_W-1:0] wr_ptr;
  logic [DEPTH_W-1:0] rd_ptr;
  logic [DEPTH_W:0]   level;
  logic [ENTRY_W-1:0] head;
  logic               store;
  logic               pop;

  assign head        = mem[rd_ptr];
  assign empty_o     = (level == {(DEPTH_W + 1){1'b0}});
  assign full_o      = (level == DEPTH_L);
  assign level_o     = level;
  assign wtb_ready_o = ~full_o;
  // Only stored entries are popped; a bypassed write never touches rd_ptr.
  assign pop         = ~empty_o & write_ready_i;

  always_comb begin
    write_valid_o = ~empty_o;
    write_addr_o  = head[ENTRY_W-1 -: WADDR_W];
    write_wdata_o = head[FE_NBYTES +: FE_DATA_W];
    write_wstrb_o = head[FE_NBYTES-1:0];
    store         = wtb_valid_i & wtb_ready_o;
`ifdef IOB_CACHE_WTB_BYPASS_EN
    if (empty_o && wtb_valid_i) begin
      write_valid_o = 1'b1;
      write_addr_o  = wtb_addr_i;
      write_wdata_o = wtb_wdata_i;
      write_wstrb_o = wtb_wstrb_i;
      store         = ~write_ready_i;
    end else begin
      write_valid_o = ~empty_o;
    end
`endif
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= {DEPTH_W{1'b0}};
      rd_ptr <= {DEPTH_W{1'b0}};
      level  <= {(DEPTH_W + 1){1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= {ENTRY_W{1'b0}};
      end
    end else begin
      if (store) begin
        mem[wr_ptr] <= {wtb_addr_i, wtb_wdata_i, wtb_wstrb_i};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({store, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: tb/tb_iob_cache_write_buffer.sv
// Self-checking bench: queue-based reference model compared every cycle, plus directed literal checks.
module tb_iob_cache_write_buffer;

  localparam int FE_ADDR_W = 24;
  localparam int FE_DATA_W = 32;
  localparam int DEPTH_W   = 2;
  localparam int DEPTH     = 4;
  localparam int AW        = 22;
  localparam int NB        = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          wtb_valid;
  logic [AW-1:0] wtb_addr;
  logic [31:0]   wtb_wdata;
  logic [NB-1:0] wtb_wstrb;
  logic          wtb_ready;
  logic          write_valid;
  logic [AW-1:0] write_addr;
  logic [31:0]   write_wdata;
  logic [NB-1:0] write_wstrb;
  logic          write_ready;
  logic          empty;
  logic          full;
  logic [2:0]    level;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
    logic [NB-1:0] strb;
  } entry_t;

  entry_t q[$];

  iob_cache_write_buffer #(
    .FE_ADDR_W(FE_ADDR_W), .FE_DATA_W(FE_DATA_W), .DEPTH_W(DEPTH_W)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .wtb_valid_i(wtb_valid), .wtb_addr_i(wtb_addr), .wtb_wdata_i(wtb_wdata),
    .wtb_wstrb_i(wtb_wstrb), .wtb_ready_o(wtb_ready),
    .write_valid_o(write_valid), .write_addr_o(write_addr), .write_wdata_o(write_wdata),
    .write_wstrb_o(write_wstrb), .write_ready_i(write_ready),
    .empty_o(empty), .full_o(full), .level_o(level)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference model: a plain FIFO of at most DEPTH entries.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
    end else begin
      bit do_push;
      bit do_pop;
      entry_t e;
      e = '{addr: wtb_addr, data: wtb_wdata, strb: wtb_wstrb};
      do_push = wtb_valid && (q.size() < DEPTH);
      do_pop  = (q.size() > 0) && write_ready;
`ifdef IOB_CACHE_WTB_BYPASS_EN
      if (q.size() == 0 && wtb_valid && write_ready) do_push = 1'b0;
`endif
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(e);
    end
  end

  // Compare DUT against the model mid-cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      bit     exp_valid;
      entry_t exp_head;
      exp_valid = (q.size() > 0);
      if (exp_valid) exp_head = q[0];
`ifdef IOB_CACHE_WTB_BYPASS_EN
      if (!exp_valid && wtb_valid && !rst) begin
        exp_valid = 1'b1;
        exp_head  = '{addr: wtb_addr, data: wtb_wdata, strb: wtb_wstrb};
      end
`endif
      check("m_level", 64'(level), 64'(q.size()));
      check("m_empty", 64'(empty), 64'(q.size() == 0));
      check("m_full", 64'(full), 64'(q.size() == DEPTH));
      check("m_wtb_ready", 64'(wtb_ready), 64'(q.size() != DEPTH));
      check("m_valid", 64'(write_valid), 64'(exp_valid));
      if (exp_valid) begin
        check("m_addr", 64'(write_addr), 64'(exp_head.addr));
        check("m_wdata", 64'(write_wdata), 64'(exp_head.data));
        check("m_wstrb", 64'(write_wstrb), 64'(exp_head.strb));
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    wtb_valid = 1'b0;
    wtb_addr = '0;
    wtb_wdata = '0;
    wtb_wstrb = '0;
    write_ready = 1'b0;
    repeat (2) next_cycle();
    chk_en = 1'b1;
    // Reset values
    check("rst_empty", 64'(empty), 64'd1);
    check("rst_level", 64'(level), 64'd0);
    check("rst_valid", 64'(write_valid), 64'd0);
    check("rst_addr", 64'(write_addr), 64'd0);
    check("rst_ready", 64'(wtb_ready), 64'd1);
    check("rst_full", 64'(full), 64'd0);
    rst = 1'b0;
    next_cycle();

    // Fill past capacity with back-end stalled
    for (int i = 0; i < 5; i++) begin
      wtb_valid = 1'b1;
      wtb_addr  = 22'h10 + 22'(i);
      wtb_wdata = 32'hA000_0000 + 32'(i);
      wtb_wstrb = 4'(i + 1);
      @(negedge clk);
      if (i == 4) begin
        check("fill_ready5", 64'(wtb_ready), 64'd0);
        check("fill_full5", 64'(full), 64'd1);
      end
      next_cycle();
    end
    wtb_valid = 1'b0;
    check("fill_level", 64'(level), 64'd4);
    check("fill_head", 64'(write_addr), 64'h10);
    check("fill_hdata", 64'(write_wdata), 64'hA000_0000);

    // Drain in order
    write_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("drain_addr", 64'(write_addr), 64'h10 + 64'(i));
      check("drain_data", 64'(write_wdata), 64'hA000_0000 + 64'(i));
      check("drain_strb", 64'(write_wstrb), 64'(i + 1));
      next_cycle();
    end
    write_ready = 1'b0;
    check("drain_empty", 64'(empty), 64'd1);

    // Push-to-head latency
    wtb_valid = 1'b1;
    wtb_addr  = 22'h2A;
    wtb_wdata = 32'hDEADBEEF;
    wtb_wstrb = 4'hF;
    @(negedge clk);
`ifndef IOB_CACHE_WTB_BYPASS_EN
    check("lat_before", 64'(write_valid), 64'd0);
`else
    check("byp_valid", 64'(write_valid), 64'd1);
`endif
    next_cycle();
    wtb_valid = 1'b0;
    check("lat_valid", 64'(write_valid), 64'd1);
    check("lat_addr", 64'(write_addr), 64'h2A);
    check("lat_data", 64'(write_wdata), 64'hDEADBEEF);
    check("lat_strb", 64'(write_wstrb), 64'hF);
    write_ready = 1'b1;
    next_cycle();
    write_ready = 1'b0;

`ifdef IOB_CACHE_WTB_BYPASS_EN
    // Direct consumption through an empty buffer
    wtb_valid = 1'b1;
    wtb_wstrb = 4'h3;
    write_ready = 1'b1;
    @(negedge clk);
    check("byp_addr", 64'(write_addr), 64'h2A);
    check("byp_strb", 64'(write_wstrb), 64'h3);
    next_cycle();
    wtb_valid = 1'b0;
    write_ready = 1'b0;
    check("byp_level", 64'(level), 64'd0);
`endif

    // Steady push+pop at level 2, pointers wrap
    for (int i = 0; i < 2; i++) begin
      wtb_valid = 1'b1;
      wtb_addr  = 22'($urandom);
      wtb_wdata = $urandom;
      wtb_wstrb = 4'($urandom);
      next_cycle();
    end
    write_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      wtb_addr  = 22'($urandom);
      wtb_wdata = $urandom;
      wtb_wstrb = (i == 3) ? 4'h0 : 4'($urandom);
      next_cycle();
    end
    check("steady_level", 64'(level), 64'd2);
    write_ready = 1'b0;
    next_cycle();
    wtb_valid = 1'b0;
    check("mid_level", 64'(level), 64'd3);

    // Asynchronous reset mid-queue
    #2;
    rst = 1'b1;
    #1;
    check("arst_empty", 64'(empty), 64'd1);
    check("arst_level", 64'(level), 64'd0);
    check("arst_valid", 64'(write_valid), 64'd0);
    check("arst_addr", 64'(write_addr), 64'd0);
    check("arst_ready", 64'(wtb_ready), 64'd1);
    next_cycle();
    rst = 1'b0;
    next_cycle();

    // Randomized traffic with shifting back-pressure
    for (int i = 0; i < 3000; i++) begin
      int rdy_pct;
      rdy_pct = (i < 1000) ? 25 : ((i < 2000) ? 75 : 50);
      wtb_valid   = ($urandom_range(0, 99) < 60);
      wtb_addr    = 22'($urandom);
      wtb_wdata   = $urandom;
      wtb_wstrb   = 4'($urandom);
      write_ready = ($urandom_range(0, 99) < rdy_pct);
      next_cycle();
    end
    wtb_valid = 1'b0;
    write_ready = 1'b1;
    repeat (6) next_cycle();
    check("final_empty", 64'(empty), 64'd1);
    chk_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/iob_cache_write_buffer.md
Name: iob_cache_write_buffer

Overview:
- Write-through buffer between the cache front-end write path and the back-end write channel.
- Queues word writes (address, data, byte strobe) issued by the cache control on a write-through hit or miss.
- Presents the queued writes in order on the back-end write_valid/write_addr/write_wdata/write_wstrb/write_ready interface.
- Reports empty/full so the cache can stall writes and detect "all writes drained" for flush and invalidate.

Parameters:
- FE_ADDR_W, 24, front-end byte-address width.
- FE_DATA_W, 32, front-end word width (multiple of 8).
- DEPTH_W, 2, log2 of entry count; DEPTH = 2**DEPTH_W, legal range 1..6.
- FE_NBYTES, FE_DATA_W/8, derived: bytes per word.
- FE_NBYTES_W, $clog2(FE_NBYTES), derived.
- ENTRY_W, (FE_ADDR_W-FE_NBYTES_W)+FE_DATA_W+FE_NBYTES, derived: stored entry width.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  asynchronous, active-high reset.
- wtb_valid_i  in  1  push request from cache control.
- wtb_addr_i  in  FE_ADDR_W-FE_NBYTES_W  word address of write.
- wtb_wdata_i  in  FE_DATA_W  write data.
- wtb_wstrb_i  in  FE_NBYTES  byte strobes.
- wtb_ready_o  out  1  push accepted this cycle when high with wtb_valid_i.
- write_valid_o  out  1  head entry valid toward back-end.
- write_addr_o  out  FE_ADDR_W-FE_NBYTES_W  head address.
- write_wdata_o  out  FE_DATA_W  head data.
- write_wstrb_o  out  FE_NBYTES  head strobes.
- write_ready_i  in  1  back-end accepts head when high with write_valid_o.
- empty_o  out  1  no entries stored.
- full_o  out  1  DEPTH entries stored.
- level_o  out  DEPTH_W+1  entry count, 0..DEPTH.

Behaviour:
- Interface decision: one clock, clk_i; rst_i is asynchronous and active-high.
- Storage: DEPTH x ENTRY_W register array with wr_ptr and rd_ptr (DEPTH_W bits each) and level (DEPTH_W+1 bits).
- Pointers wrap modulo DEPTH by natural overflow.
- Reset (async, immediate): wr_ptr=0, rd_ptr=0, level=0, array cleared to 0. Outputs: empty_o=1, full_o=0, level_o=0, write_valid_o=0, wtb_ready_o=1, write_addr_o/wdata_o/wstrb_o=0.
- Push: push = wtb_valid_i & wtb_ready_o. On push, the entry is written at wr_ptr and wr_ptr increments.
- wtb_ready_o = ~full_o. It is combinational from registered state only; there is no push-through when full, even if a pop occurs in the same cycle.
- Pop: pop = write_valid_o & write_ready_i. On pop, rd_ptr increments.
- write_valid_o = ~empty_o. write_*_o are combinational reads of array[rd_ptr].
- Level update per clock:
  - push only: +1.
  - pop only: -1.
  - both: unchanged.
  - neither: unchanged.
- empty_o = (level==0); full_o = (level==DEPTH). Both are derived from the registered level.
- Latency (base build): a push at edge N makes write_valid_o high after edge N, i.e. 1 cycle from push to visible head.
- Ordering: strict FIFO. No merging and no reordering. Strobes are passed through unmodified, including all-zero wstrb.
- Head stability: write_*_o do not change while write_valid_o=1 and write_ready_i=0. A concurrent push writes only the wr_ptr slot, never the rd_ptr slot, because the buffer is not empty.
- Back-end protocol: write_ready_i may be high while write_valid_o=0; this has no effect.
- Reset mid-operation: all queued entries are discarded and outputs return to reset values asynchronously. A partially accepted back-end write is the back-end's concern.

Optional Feature:
- Macro: IOB_CACHE_WTB_BYPASS_EN.
- Defined:
  - When empty_o=1 and wtb_valid_i=1, write_valid_o=1 and write_*_o = wtb_*_i combinationally in the same cycle.
  - If write_ready_i=1 in that cycle, the write is consumed directly: nothing is stored and level stays 0.
  - Otherwise the entry is stored normally.
  - Push-to-head latency drops to 0 cycles.
  - empty_o still reflects stored level only.
- Not defined: base behaviour, 1-cycle latency, and no combinational path from wtb_* to write_*.

Test Plan:
- Reset with rst_i=1 mid-queue (level=3) -> next sample: empty_o=1, level_o=0, write_valid_o=0, write_addr_o=0, wtb_ready_o=1.
- DEPTH=4, write_ready_i=0, push addr 0x10..0x14 (5 valid cycles) -> first 4 accepted, full_o=1, wtb_ready_o=0 on the 5th; level_o=4; head addr=0x10 held stable.
- From full, write_ready_i=1 for 4 cycles, no push -> pops addr 0x10,0x11,0x12,0x13 in order with matching wdata/wstrb; empty_o=1 after the 4th.
- Continuous push and pop for 10 cycles starting at level 2 -> level_o stays 2; rd_ptr and wr_ptr wrap past 3→0; output sequence equals input sequence.
- Base build, empty, push addr 0x2A wdata 0xDEADBEEF wstrb 0xF at edge N -> write_valid_o=0 before N; after N, write_valid_o=1 with those values.
- IOB_CACHE_WTB_BYPASS_EN defined, empty, push 0x2A/0xDEADBEEF/0x3 with write_ready_i=1 -> same cycle write_valid_o=1 with those values; afterwards level_o=0, empty_o=1.
